// File: rtl/thresholding_cfg_pkg.sv
// Shared types and helpers for loading a thresholding_axi threshold table.
// cfg_word_addr is also used by target-side benches to build expected addresses.
package thresholding_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    RESP,
    DONE
  } cfg_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Word address {cf, pe, t}; zero-width fields collapse because their value is always 0.
  function automatic logic [31:0] cfg_word_addr(input logic [31:0] cf,
                                                input logic [31:0] pe,
                                                input logic [31:0] t,
                                                input int          pe_bits,
                                                input int          n_bits);
    return (cf << (pe_bits + n_bits)) | (pe << n_bits) | t;
  endfunction

endpackage

// File: rtl/thresholding_cfg_addr_gen.sv
// Nested t/pe/cf counters walking the threshold table in channel-major order.
// Produces the byte address of the current word and flags the final word.
module thresholding_cfg_addr_gen
  import thresholding_cfg_pkg::*;
#(
  parameter int N         = 2,
  parameter int C         = 4,
  parameter int PE        = 2,
  parameter int ADDR_BITS = $clog2(C / PE) + $clog2(PE) + N + 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clear,
  input  logic                 advance,
  output logic [ADDR_BITS-1:0] byte_addr,
  output logic                 last
);

  localparam int TPC  = (1 << N) - 1;
  localparam int CF_N = C / PE;
  localparam int PEB  = $clog2(PE);
  localparam int CFB  = $clog2(CF_N);
  localparam int PEW  = (PEB > 0) ? PEB : 1;
  localparam int CFW  = (CFB > 0) ? CFB : 1;

  localparam logic [N-1:0]   T_LAST  = N'(TPC - 1);
  localparam logic [PEW-1:0] PE_LAST = PEW'(PE - 1);
  localparam logic [CFW-1:0] CF_LAST = CFW'(CF_N - 1);

  logic [N-1:0]   t_q;
  logic [PEW-1:0] pe_q;
  logic [CFW-1:0] cf_q;

  // t is the fastest index, then pe, then cf; the last word is never advanced past.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      t_q  <= '0;
      pe_q <= '0;
      cf_q <= '0;
    end else if (clear) begin
      t_q  <= '0;
      pe_q <= '0;
      cf_q <= '0;
    end else if (advance) begin
      if (t_q == T_LAST) begin
        t_q <= '0;
        if (pe_q == PE_LAST) begin
          pe_q <= '0;
          cf_q <= cf_q + 1'b1;
        end else begin
          pe_q <= pe_q + 1'b1;
        end
      end else begin
        t_q <= t_q + 1'b1;
      end
    end
  end

  assign last = (t_q == T_LAST) && (pe_q == PE_LAST) && (cf_q == CF_LAST);

  assign byte_addr = ADDR_BITS'(cfg_word_addr(32'(cf_q), 32'(pe_q), 32'(t_q), PEB, N) << 2);

endmodule

// File: rtl/thresholding_cfg_loader.sv
// Streams a full threshold table from AXI-Stream into a thresholding_axi target,
// one AXI-Lite write per word, and reports completion and any error response.
module thresholding_cfg_loader
  import thresholding_cfg_pkg::*;
#(
  parameter int N         = 2,
  parameter int WT        = 8,
  parameter int C         = 1,
  parameter int PE        = 1,
  parameter int ADDR_BITS = $clog2(C / PE) + $clog2(PE) + N + 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tvalid,
  input  logic [((WT+7)/8)*8-1:0]     s_axis_tdata,
  output logic                        m_AWVALID,
  input  logic                        m_AWREADY,
  output logic [ADDR_BITS-1:0]        m_AWADDR,
  output logic                        m_WVALID,
  input  logic                        m_WREADY,
  output logic [31:0]                 m_WDATA,
  output logic [3:0]                  m_WSTRB,
  input  logic                        m_BVALID,
  output logic                        m_BREADY,
  input  logic [1:0]                  m_BRESP
);

  localparam int DW = ((WT + 7) / 8) * 8;
  localparam logic [DW-1:0] WT_MASK = DW'((64'd1 << WT) - 64'd1);

  cfg_state_t    state_q, state_d;
  logic [DW-1:0] data_q;
  logic          aw_done_q, w_done_q, err_q;
  logic          aw_hs, w_hs, issue_complete;
  logic          ctr_clear, ctr_advance, last_word;

  thresholding_cfg_addr_gen #(
    .N        (N),
    .C        (C),
    .PE       (PE),
    .ADDR_BITS(ADDR_BITS)
  ) u_addr_gen (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clear    (ctr_clear),
    .advance  (ctr_advance),
    .byte_addr(m_AWADDR),
    .last     (last_word)
  );

  assign aw_hs          = m_AWVALID && m_AWREADY;
  assign w_hs           = m_WVALID && m_WREADY;
  assign issue_complete = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // Outputs decode only registered state, so no READY reaches a VALID combinationally.
  always_comb begin
    state_d       = state_q;
    ctr_clear     = 1'b0;
    ctr_advance   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    s_axis_tready = 1'b0;
    m_AWVALID     = 1'b0;
    m_WVALID      = 1'b0;
    m_BREADY      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          ctr_clear = 1'b1;
        end
      end
      FETCH: begin
        busy          = 1'b1;
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        m_AWVALID = !aw_done_q;
        m_WVALID  = !w_done_q;
        if (issue_complete) state_d = RESP;
      end
      RESP: begin
        busy     = 1'b1;
        m_BREADY = 1'b1;
        if (m_BVALID) begin
          if (m_BRESP != AXI_RESP_OKAY || last_word) begin
            state_d = DONE;
          end else begin
            state_d     = FETCH;
            ctr_advance = 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-channel accept flags let AW and W complete in either order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      data_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == FETCH && s_axis_tvalid) data_q <= s_axis_tdata;
      if (state_q != ISSUE) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (state_q == IDLE && start) begin
        err_q <= 1'b0;
      end else if (state_q == RESP && m_BVALID && m_BRESP != AXI_RESP_OKAY) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err     = err_q;
  assign m_WDATA = 32'(data_q & WT_MASK);
  assign m_WSTRB = 4'hF;

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Directed bench for thresholding_cfg_loader with C=4, PE=2, N=2, WT=8 and
// simple stream-source and AXI-Lite slave models.
module tb_thresholding_cfg_loader;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        start;
  logic        busy, done, err;
  logic        s_axis_tready, s_axis_tvalid;
  logic [7:0]  s_axis_tdata;
  logic        m_AWVALID, m_AWREADY;
  logic [5:0]  m_AWADDR;
  logic        m_WVALID, m_WREADY;
  logic [31:0] m_WDATA;
  logic [3:0]  m_WSTRB;
  logic        m_BVALID, m_BREADY;
  logic [1:0]  m_BRESP;

  int errors = 0;
  int checks = 0;

  thresholding_cfg_loader #(.N(2), .WT(8), .C(4), .PE(2)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .s_axis_tready(s_axis_tready),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .m_AWVALID    (m_AWVALID),
    .m_AWREADY    (m_AWREADY),
    .m_AWADDR     (m_AWADDR),
    .m_WVALID     (m_WVALID),
    .m_WREADY     (m_WREADY),
    .m_WDATA      (m_WDATA),
    .m_WSTRB      (m_WSTRB),
    .m_BVALID     (m_BVALID),
    .m_BREADY     (m_BREADY),
    .m_BRESP      (m_BRESP)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Channel-major order {cf,pe,t} for C=4, PE=2, TPC=3, worked out by hand.
  logic [5:0] exp_addr [0:11] = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18,
                                  6'h20, 6'h24, 6'h28, 6'h30, 6'h34, 6'h38};

  int cyc = 0;
  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  // Stream source: words 1..12, optionally offered only every fourth cycle.
  int stream_idx = 0;
  bit gap_mode   = 0;
  bit s_hs;
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge ap_clk);
      s_hs = s_axis_tvalid && s_axis_tready;
      @(posedge ap_clk);
      #2;
      if (s_hs) stream_idx++;
      if (stream_idx < 12) begin
        s_axis_tvalid = (s_axis_tvalid && !s_hs) || !gap_mode || (cyc % 4 == 0);
        s_axis_tdata  = 8'(stream_idx + 1);
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  end

  // AXI-Lite slave with programmable READY delays and one optional error response.
  int aw_delay = 0, w_delay = 0, bad_idx = -1;
  int aw_wait = 0, w_wait = 0, b_cnt = 0;
  logic [5:0]  aw_log [$];
  logic [31:0] w_log  [$];
  int aw_run = 0, w_run = 0, max_aw_run = 0, max_w_run = 0, unstable = 0, done_cnt = 0;
  bit aw_pend = 0, w_pend = 0;
  logic [5:0]  aw_prev;
  logic [31:0] w_prev;
  bit aw_hs, w_hs, b_hs;
  initial begin
    m_AWREADY = 1'b0;
    m_WREADY  = 1'b0;
    m_BVALID  = 1'b0;
    m_BRESP   = 2'b00;
    forever begin
      @(negedge ap_clk);
      aw_hs = m_AWVALID && m_AWREADY;
      w_hs  = m_WVALID && m_WREADY;
      b_hs  = m_BVALID && m_BREADY;
      if (done) done_cnt++;
      if (m_AWVALID) begin
        if (aw_pend && m_AWADDR !== aw_prev) unstable++;
        aw_run++;
      end
      aw_pend = m_AWVALID && !aw_hs;
      aw_prev = m_AWADDR;
      if (aw_hs) begin
        aw_log.push_back(m_AWADDR);
        if (aw_run > max_aw_run) max_aw_run = aw_run;
        aw_run = 0;
      end
      if (m_WVALID) begin
        if (w_pend && m_WDATA !== w_prev) unstable++;
        w_run++;
      end
      w_pend = m_WVALID && !w_hs;
      w_prev = m_WDATA;
      if (w_hs) begin
        w_log.push_back(m_WDATA);
        if (w_run > max_w_run) max_w_run = w_run;
        w_run = 0;
      end
      @(posedge ap_clk);
      #2;
      if (b_hs) b_cnt++;
      aw_wait   = m_AWVALID ? aw_wait + 1 : 0;
      w_wait    = m_WVALID ? w_wait + 1 : 0;
      m_AWREADY = m_AWVALID && (aw_wait > aw_delay);
      m_WREADY  = m_WVALID && (w_wait > w_delay);
      m_BVALID  = (aw_log.size() > b_cnt) && (w_log.size() > b_cnt);
      m_BRESP   = (b_cnt == bad_idx) ? 2'b10 : 2'b00;
    end
  end

  task automatic clear_logs(input int awd, input int wd, input int bad, input bit gap);
    aw_delay = awd;  w_delay = wd;  bad_idx = bad;  gap_mode = gap;
    aw_log.delete();  w_log.delete();
    b_cnt = 0;  aw_run = 0;  w_run = 0;  max_aw_run = 0;  max_w_run = 0;
    unstable = 0;  done_cnt = 0;  aw_pend = 0;  w_pend = 0;
    stream_idx = 0;  s_axis_tvalid = 1'b0;  s_axis_tdata = 8'h01;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  // Pulses start and counts cycles until done; optionally re-pulses start mid-load.
  task automatic run_load(input bit poke_start, output int cycles,
                          output bit busy_at1, output bit err_at1);
    @(posedge ap_clk); #1;
    start = 1'b1;
    @(posedge ap_clk); #1;
    start    = 1'b0;
    cycles   = 1;
    busy_at1 = busy;
    err_at1  = err;
    while (!done && cycles < 2000) begin
      start = poke_start && (cycles % 5 == 2);
      @(posedge ap_clk); #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    start    = 1'b0;
    wait_cycles(3);
    checks++;
    if ({busy, done, err, s_axis_tready, m_AWVALID, m_WVALID, m_BREADY} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000000",
               {busy, done, err, s_axis_tready, m_AWVALID, m_WVALID, m_BREADY});
    end
    checks++;
    if (m_WSTRB !== 4'hF) begin
      errors++;
      $display("[TB] FAIL wstrb: got %h expected f", m_WSTRB);
    end
    ap_rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic check_table(input string name);
    checks++;
    if (aw_log.size() !== 12 || w_log.size() !== 12) begin
      errors++;
      $display("[TB] FAIL %s_count: got aw=%0d w=%0d expected 12/12", name, aw_log.size(), w_log.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (aw_log[i] !== exp_addr[i] || w_log[i] !== 32'(i + 1)) begin
          errors++;
          $display("[TB] FAIL %s_word%0d: got addr=%h data=%h expected addr=%h data=%h",
                   name, i, aw_log[i], w_log[i], exp_addr[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_basic_load();
    int cycles;
    bit b1, e1;
    clear_logs(0, 0, -1, 0);
    run_load(0, cycles, b1, e1);
    checks++;
    if (cycles !== 37) begin
      errors++;
      $display("[TB] FAIL basic_cycles: got %0d expected 37", cycles);
    end
    checks++;
    if (b1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy_after_start: got %b expected 1", b1);
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_err_busy_at_done: got err=%b busy=%b expected 0/0", err, busy);
    end
    check_table("basic");
    checks++;
    if (max_aw_run !== 1 || max_w_run !== 1) begin
      errors++;
      $display("[TB] FAIL basic_valid_len: got aw=%0d w=%0d expected 1/1", max_aw_run, max_w_run);
    end
    wait_cycles(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done_pulse: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_aw_delay();
    int cycles;
    bit b1, e1;
    clear_logs(3, 0, -1, 0);
    run_load(0, cycles, b1, e1);
    checks++;
    if (cycles !== 73) begin
      errors++;
      $display("[TB] FAIL awdelay_cycles: got %0d expected 73", cycles);
    end
    check_table("awdelay");
    checks++;
    if (max_aw_run !== 4 || max_w_run !== 1) begin
      errors++;
      $display("[TB] FAIL awdelay_valid_len: got aw=%0d w=%0d expected 4/1", max_aw_run, max_w_run);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("[TB] FAIL awdelay_stability: got %0d changes expected 0", unstable);
    end
    wait_cycles(2);
  endtask

  task automatic test_bresp_error();
    int cycles;
    bit b1, e1;
    bit tready_seen;
    clear_logs(0, 0, 4, 0);
    run_load(0, cycles, b1, e1);
    checks++;
    if (cycles !== 16 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bresp_done: got cycles=%0d err=%b expected 16/1", cycles, err);
    end
    tready_seen = 0;
    for (int i = 0; i < 6; i++) begin
      wait_cycles(1);
      if (s_axis_tready || m_AWVALID) tready_seen = 1;
    end
    checks++;
    if (tready_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bresp_stopped: got activity=%b expected 0", tready_seen);
    end
    checks++;
    if (aw_log.size() !== 5 || err !== 1'b1 || done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL bresp_writes: got aw=%0d err=%b done=%0d expected 5/1/1",
               aw_log.size(), err, done_cnt);
    end
  endtask

  task automatic test_gapped_stream();
    int cycles;
    bit b1, e1;
    clear_logs(0, 0, -1, 1);
    run_load(0, cycles, b1, e1);
    checks++;
    if (e1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gapped_err_cleared: got %b expected 0", e1);
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gapped_done: got done=%b err=%b after %0d cycles expected 1/0", done, err, cycles);
    end
    check_table("gapped");
    wait_cycles(2);
  endtask

  task automatic test_reset_mid_load();
    int n, cycles;
    bit b1, e1;
    clear_logs(3, 3, -1, 0);
    @(posedge ap_clk); #1;
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    n = 0;
    while (!(aw_log.size() == 2 && m_AWVALID === 1'b1) && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL midreset_reach_word3: got timeout after %0d cycles expected issue of word 3", n);
    end
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, s_axis_tready, m_AWVALID, m_WVALID, m_BREADY} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b expected 0000000",
               {busy, done, err, s_axis_tready, m_AWVALID, m_WVALID, m_BREADY});
    end
    checks++;
    if (w_log.size() !== 2) begin
      errors++;
      $display("[TB] FAIL midreset_no_partial: got %0d W beats expected 2", w_log.size());
    end
    wait_cycles(2);
    clear_logs(0, 0, -1, 0);
    ap_rst_n = 1'b1;
    wait_cycles(2);
    run_load(0, cycles, b1, e1);
    checks++;
    if (cycles !== 37) begin
      errors++;
      $display("[TB] FAIL midreset_reload_cycles: got %0d expected 37", cycles);
    end
    check_table("midreset");
    wait_cycles(2);
  endtask

  task automatic test_start_while_busy();
    int cycles;
    bit b1, e1;
    clear_logs(0, 0, -1, 0);
    run_load(1, cycles, b1, e1);
    wait_cycles(10);
    checks++;
    if (cycles !== 37 || done_cnt !== 1 || aw_log.size() !== 12) begin
      errors++;
      $display("[TB] FAIL busy_start: got cycles=%0d done=%0d writes=%0d expected 37/1/12",
               cycles, done_cnt, aw_log.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_start_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_aw_delay();
    test_bresp_error();
    test_gapped_stream();
    test_reset_mid_load();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
